result_ddr_writeback: RTL and testbench

//  Drains a result (output) buffer bank group to DDR: once configured, it reads BANK_NUM banks of 512-bit words.

---
 rtl/result_ddr_writeback_if.sv | 27 ++
 rtl/result_ddr_writeback.sv | 152 +++++++++++++++
 tb/tb_result_ddr_writeback.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_ddr_writeback_if.sv
// Result DDR write-channel interface.
// Bundles the job descriptor (ddr_st_addr_out, ddr_len, ddr_conf) and the
// DDR write FIFO push port (ddr_fifo_wreq, ddr_fifo_wdata, ddr_fifo_full).
//   master : the writeback engine (drives descriptor and push, sees full)
//   slave  : the DDR write master / FIFO side
interface result_ddr_writeback_if #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24
);
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    ddr_fifo_full;
  logic                    ddr_fifo_wreq;
  logic [DATA_LEN*8-1:0]   ddr_fifo_wdata;

  modport master (
    output ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_wreq, ddr_fifo_wdata,
    input  ddr_fifo_full
  );

  modport slave (
    input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_wreq, ddr_fifo_wdata,
    output ddr_fifo_full
  );
endinterface

// File: rtl/result_ddr_writeback.sv
// Result buffer -> DDR writeback engine.
// Reads BANK_NUM output-buffer banks bank-major (bank 0 words ob_st..ob_st+n-1,
// then bank 1, ...) and pushes every word into the DDR write FIFO.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   conf, word_num, ddr_st_addr,
//   ob_st_addr                     job start and parameters (sampled in IDLE)
//   ddr                            DDR descriptor + write FIFO (master modport)
//   ob_addr, ob_rd_en, ob_rdata    output-buffer read port (1-cycle latency)
//   idle, done                     status
module result_ddr_writeback #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24,
  parameter int BANK_NUM     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          word_num,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            ob_st_addr,
  result_ddr_writeback_if.master         ddr,
  output logic [ADDR_LEN-1:0]            ob_addr,
  output logic [BANK_NUM-1:0]            ob_rd_en,
  input  logic [DATA_LEN*8*BANK_NUM-1:0] ob_rdata,
  output logic                           idle,
  output logic                           done
);

  localparam int WORD_W = DATA_LEN * 8;
  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam logic [SINGLE_LEN-1:0] ROW_BYTES = SINGLE_LEN'(BANK_NUM * DATA_LEN);
  localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(BANK_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONF, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_next;
  logic [SINGLE_LEN-1:0] word_num_q;
  logic [ADDR_LEN-1:0]   ob_st_q;
  logic [SINGLE_LEN-1:0] offset;
  logic [BANK_W-1:0]     bank;
  logic                  inflight;
  logic [BANK_W-1:0]     inflight_bank;
  logic [WORD_W-1:0]     skid [2];
  logic [1:0]            skid_count;
  logic                  zero_done;

  logic                  push;
  logic                  issue;
  logic                  last_read;
  logic                  wr_idx;
  logic [1:0]            occupancy;
  logic [WORD_W-1:0]     bank_words [BANK_NUM];
  logic [WORD_W-1:0]     cap_data;

  // Split the wide read bus into per-bank words so the returning bank can be
  // selected by the bank index registered alongside the read.
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_words[b] = ob_rdata[b*WORD_W +: WORD_W];
    end
  end

  // Read issue looks at the occupancy left after this cycle's push, so a read
  // can go out while the head word leaves; that is what sustains one word per
  // cycle with only two slots, and skid + in-flight still never exceeds two.
  always_comb begin
    cap_data  = bank_words[inflight_bank];
    push      = (skid_count != 2'd0) && !ddr.ddr_fifo_full;
    occupancy = skid_count + {1'b0, inflight} - {1'b0, push};
    issue     = (state == S_READ) && (occupancy < 2'd2);
    last_read = (bank == LAST_BANK) && (offset == word_num_q - 1'b1);
    wr_idx    = (skid_count == 2'd2) || ((skid_count == 2'd1) && !push);
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_next         = state;
    ob_rd_en           = '0;
    ob_addr            = ob_st_q + ADDR_LEN'(offset);
    ddr.ddr_fifo_wreq  = push;
    ddr.ddr_fifo_wdata = skid[0];
    idle               = (state == S_IDLE);
    done               = (state == S_DONE) || zero_done;
    if (issue) begin
      ob_rd_en = {{(BANK_NUM-1){1'b0}}, 1'b1} << bank;
    end
    case (state)
      S_IDLE:  if (conf && (word_num != '0)) state_next = S_CONF;
      S_CONF:  state_next = S_READ;
      S_READ:  if (issue && last_read) state_next = S_DRAIN;
      // Last word leaves when nothing is in flight and the only skid entry pushes.
      S_DRAIN: if (!inflight && (skid_count == {1'b0, push})) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Job latch, descriptor, read counters and the two-entry skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_num_q          <= '0;
      ob_st_q             <= '0;
      offset              <= '0;
      bank                <= '0;
      inflight            <= 1'b0;
      inflight_bank       <= '0;
      skid[0]             <= '0;
      skid[1]             <= '0;
      skid_count          <= 2'd0;
      zero_done           <= 1'b0;
      ddr.ddr_st_addr_out <= '0;
      ddr.ddr_len         <= '0;
      ddr.ddr_conf        <= 1'b0;
    end else begin
      ddr.ddr_conf <= 1'b0;
      zero_done    <= (state == S_IDLE) && conf && (word_num == '0);
      if ((state == S_IDLE) && conf && (word_num != '0)) begin
        word_num_q          <= word_num;
        ob_st_q             <= ob_st_addr;
        offset              <= '0;
        bank                <= '0;
        ddr.ddr_st_addr_out <= ddr_st_addr;
        ddr.ddr_len         <= word_num * ROW_BYTES;
        ddr.ddr_conf        <= 1'b1;
      end else if (issue) begin
        if (offset == word_num_q - 1'b1) begin
          offset <= '0;
          bank   <= bank + 1'b1;
        end else begin
          offset <= offset + 1'b1;
        end
      end
      inflight      <= issue;
      inflight_bank <= bank;
      // Shift on push first; a capture in the same cycle lands behind the
      // surviving entries, so the later assignment wins where they overlap.
      if (push) skid[0] <= skid[1];
      if (inflight) skid[wr_idx] <= cap_data;
      skid_count <= skid_count + {1'b0, inflight} - {1'b0, push};
    end
  end

endmodule

// File: tb/tb_result_ddr_writeback.sv
// Testbench for result_ddr_writeback: randomized FIFO back-pressure, a
// behavioural buffer memory and a queue-based model of the expected bank-major
// read and push order.
module tb_result_ddr_writeback;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          conf;
  logic [23:0]   word_num;
  logic [31:0]   ddr_st_addr;
  logic [15:0]   ob_st_addr;
  logic [15:0]   ob_addr;
  logic [7:0]    ob_rd_en;
  logic [4095:0] ob_rdata;
  logic          idle;
  logic          done;

  result_ddr_writeback_if ddr_if ();

  result_ddr_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .conf        (conf),
    .word_num    (word_num),
    .ddr_st_addr (ddr_st_addr),
    .ob_st_addr  (ob_st_addr),
    .ddr         (ddr_if.master),
    .ob_addr     (ob_addr),
    .ob_rd_en    (ob_rd_en),
    .ob_rdata    (ob_rdata),
    .idle        (idle),
    .done        (done)
  );

  always #5 clk = ~clk;

  int           num_checks = 0;
  int           num_fail = 0;
  logic [23:0]  rd_q[$];
  logic [511:0] wr_q[$];
  int           read_count, push_count, conf_count, done_count;
  logic [23:0]  seen_len;
  logic [31:0]  seen_addr;
  bit           monitor_on = 1'b0;
  int           full_mode = 0;
  int           hold_left = 0;
  bit           hold_done = 1'b0;
  logic [7:0]   salt = 8'h00;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Content of buffer word (bank, addr) for the current job.
  function automatic logic [511:0] bufWord(input int b, input logic [15:0] a);
    logic [511:0] w;
    logic [31:0]  t;
    t = {salt, 8'(b), a};
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = t ^ (32'h9E3779B9 * i);
    return w;
  endfunction

  function automatic logic [511:0] randWord();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Behavioural output buffer: 1-cycle read latency, unselected banks carry garbage.
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (ob_rd_en[b]) ob_rdata[b*512 +: 512] <= bufWord(b, ob_addr);
      else             ob_rdata[b*512 +: 512] <= randWord();
    end
  end

  // FIFO full driver: 0 = never full, 1 = random 50%, 2 = one 20-cycle hold mid-job.
  initial begin
    ddr_if.ddr_fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        1: ddr_if.ddr_fifo_full = 1'($urandom_range(0, 1));
        2: begin
          if (hold_left > 0) begin
            ddr_if.ddr_fifo_full = 1'b1;
            hold_left--;
          end else begin
            ddr_if.ddr_fifo_full = 1'b0;
            if (!hold_done && push_count >= 6) begin
              hold_done = 1'b1;
              hold_left = 19;
              ddr_if.ddr_fifo_full = 1'b1;
            end
          end
        end
        default: ddr_if.ddr_fifo_full = 1'b0;
      endcase
    end
  end

  // Monitor: compare reads and pushes against the model queues.
  always @(negedge clk) begin
    if (monitor_on && rst_n) begin
      if (ob_rd_en != 8'h00) begin
        int bk;
        bk = 0;
        for (int i = 0; i < 8; i++) if (ob_rd_en[i]) bk = i;
        checkOutput("rd_onehot", 512'($countones(ob_rd_en)), 512'(1));
        if (rd_q.size() == 0) checkOutput("rd_unexpected", 512'(ob_rd_en), 512'(0));
        else checkOutput("rd_bank_addr", 512'({8'(bk), ob_addr}), 512'(rd_q.pop_front()));
        read_count++;
      end
      if (ddr_if.ddr_fifo_wreq) begin
        checkOutput("wreq_while_full", 512'(ddr_if.ddr_fifo_full), 512'(0));
        if (wr_q.size() == 0) checkOutput("wreq_unexpected", 512'(ddr_if.ddr_fifo_wreq), 512'(0));
        else checkOutput("wdata", ddr_if.ddr_fifo_wdata, wr_q.pop_front());
        push_count++;
      end
      if (ddr_if.ddr_conf) begin
        conf_count++;
        seen_len  = ddr_if.ddr_len;
        seen_addr = ddr_if.ddr_st_addr_out;
      end
      if (done) done_count++;
      checkOutput("outstanding_le_2", 512'((read_count - push_count) <= 2), 512'(1));
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_idle"}, 512'(idle), 512'(1));
    checkOutput({tag, "_done"}, 512'(done), 512'(0));
    checkOutput({tag, "_rd_en"}, 512'(ob_rd_en), 512'(0));
    checkOutput({tag, "_ob_addr"}, 512'(ob_addr), 512'(0));
    checkOutput({tag, "_wreq"}, 512'(ddr_if.ddr_fifo_wreq), 512'(0));
    checkOutput({tag, "_wdata"}, ddr_if.ddr_fifo_wdata, 512'(0));
    checkOutput({tag, "_ddr_conf"}, 512'(ddr_if.ddr_conf), 512'(0));
    checkOutput({tag, "_ddr_len"}, 512'(ddr_if.ddr_len), 512'(0));
    checkOutput({tag, "_ddr_addr"}, 512'(ddr_if.ddr_st_addr_out), 512'(0));
  endtask

  // Run one job; abort_at > 0 pulls reset once that many words have been pushed.
  task automatic applyStimulus(input logic [23:0] wn, input logic [15:0] obs, input logic [31:0] dst,
                               input int mode, input int abort_at);
    int          edges, first_wreq, last_wreq, total;
    bit          finished;
    logic [15:0] a;
    salt = 8'($urandom);
    rd_q.delete();
    wr_q.delete();
    read_count = 0; push_count = 0; conf_count = 0; done_count = 0;
    hold_done = 1'b0; hold_left = 0;
    total = 8 * int'(wn);
    for (int b = 0; b < 8; b++) begin
      for (int o = 0; o < int'(wn); o++) begin
        a = obs + 16'(o);
        rd_q.push_back({8'(b), a});
        wr_q.push_back(bufWord(b, a));
      end
    end
    full_mode  = mode;
    monitor_on = 1'b1;
    @(negedge clk);
    conf = 1'b1; word_num = wn; ob_st_addr = obs; ddr_st_addr = dst;
    @(posedge clk);
    #1;
    conf = 1'b0; word_num = 24'($urandom); ob_st_addr = 16'($urandom); ddr_st_addr = $urandom;
    if (wn == 24'd0) begin
      checkOutput("zero_done_next", 512'(done), 512'(1));
      repeat (3) @(negedge clk);
      checkOutput("zero_ddr_conf", 512'(conf_count), 512'(0));
      checkOutput("zero_reads", 512'(read_count), 512'(0));
      checkOutput("zero_done_count", 512'(done_count), 512'(1));
      return;
    end
    edges = 0; first_wreq = -1; last_wreq = -1; finished = 1'b0;
    while (!finished && edges < 2000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ddr_if.ddr_fifo_wreq) begin
        if (first_wreq < 0) first_wreq = edges;
        last_wreq = edges;
      end
      if (abort_at > 0 && push_count >= abort_at) begin
        monitor_on = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midjob_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) finished = 1'b1;
    end
    checkOutput("done_seen", 512'(finished), 512'(1));
    repeat (3) @(negedge clk);
    checkOutput("ddr_conf_count", 512'(conf_count), 512'(1));
    checkOutput("ddr_len", 512'(seen_len), 512'(24'(int'(wn) * 512)));
    checkOutput("ddr_st_addr_out", 512'(seen_addr), 512'(dst));
    checkOutput("read_count", 512'(read_count), 512'(total));
    checkOutput("push_count", 512'(push_count), 512'(total));
    checkOutput("model_words_left", 512'(wr_q.size()), 512'(0));
    checkOutput("done_count", 512'(done_count), 512'(1));
    checkOutput("idle_after", 512'(idle), 512'(1));
    if (mode == 0) begin
      checkOutput("first_wreq_latency", 512'(first_wreq), 512'(3));
      checkOutput("wreq_back_to_back", 512'(last_wreq - first_wreq + 1), 512'(total));
    end
  endtask

  initial begin
    rst_n = 1'b0; conf = 1'b0; word_num = '0; ddr_st_addr = '0; ob_st_addr = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] T1 basic job, FIFO never full");
    applyStimulus(24'd4, 16'h0010, 32'h0000_1000, 0, 0);
    $display("[TB] T2 random back-pressure");
    applyStimulus(24'd4, 16'h0010, 32'h0000_1000, 1, 0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(24'($urandom_range(1, 6)), 16'($urandom), $urandom, 1, 0);
    end
    $display("[TB] T3 FIFO held full mid-job");
    applyStimulus(24'd4, 16'h0010, 32'h0000_1000, 2, 0);
    $display("[TB] T4 zero-length job");
    applyStimulus(24'd0, 16'h0010, 32'h0000_1000, 0, 0);
    $display("[TB] T5 buffer address wrap");
    applyStimulus(24'd3, 16'hFFFE, 32'h0000_2000, 1, 0);
    $display("[TB] T6 reset mid-job then rerun");
    applyStimulus(24'd4, 16'h0010, 32'h0000_1000, 0, 10);
    applyStimulus(24'd4, 16'h0010, 32'h0000_1000, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
